// File: rtl/jtag_tap_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_oversampled
// Description : IEEE 1149.1 TAP controller running entirely in the clk domain.
//               The JTAG pins are oversampled, TCK edges are detected, and the
//               16-state TAP FSM advances on detected TCK rises. Provides IR,
//               BYPASS, IDCODE and one 32-bit user DR with capture/update
//               pulses toward the debug unit.
// Ports       : clk, rst_n            system clock, async active-low reset
//               tck_i/tms_i/tdi_i     JTAG pins (asynchronous to clk)
//               trstn_i               JTAG reset pin, active low
//               tdo_o, tdo_en_o       JTAG data out and its enable
//               tap_reset_o           FSM is in Test-Logic-Reset
//               user_capture_o/_i     capture pulse / data captured into user DR
//               user_update_o         pulse: user_data_o freshly updated
//               user_data_o           user DR value latched on Update-DR
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_oversampled #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h249511C3,
  parameter logic [IR_WIDTH-1:0] USER_IR      = 4'b1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tck_i,
  input  logic        trstn_i,
  input  logic        tms_i,
  input  logic        tdi_i,
  output logic        tdo_o,
  output logic        tdo_en_o,
  output logic        tap_reset_o,
  output logic        user_capture_o,
  input  logic [31:0] user_capture_i,
  output logic        user_update_o,
  output logic [31:0] user_data_o
);

  localparam logic [3:0] TLR    = 4'd0;
  localparam logic [3:0] RTI    = 4'd1;
  localparam logic [3:0] SELDR  = 4'd2;
  localparam logic [3:0] CAPDR  = 4'd3;
  localparam logic [3:0] SHDR   = 4'd4;
  localparam logic [3:0] EX1DR  = 4'd5;
  localparam logic [3:0] PAUSDR = 4'd6;
  localparam logic [3:0] EX2DR  = 4'd7;
  localparam logic [3:0] UPDDR  = 4'd8;
  localparam logic [3:0] SELIR  = 4'd9;
  localparam logic [3:0] CAPIR  = 4'd10;
  localparam logic [3:0] SHIR   = 4'd11;
  localparam logic [3:0] EX1IR  = 4'd12;
  localparam logic [3:0] PAUSIR = 4'd13;
  localparam logic [3:0] EX2IR  = 4'd14;
  localparam logic [3:0] UPDIR  = 4'd15;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  // Two-flop synchronisers; index 1 is the synchronised value.
  logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trstn_sync_q;
  logic       tck_prev_q;

  logic [3:0]          state_q, state_d, tap_next;
  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [31:0]         dr_shift_q, dr_shift_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic [31:0]         user_data_q, user_data_d;
  logic                user_capture_q, user_capture_d;
  logic                user_update_q, user_update_d;

  logic tck_s, tms_s, tdi_s, trst;
  logic tck_rise, tck_fall;
  logic sel_idcode, sel_user;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync_q   <= '0;
      tms_sync_q   <= '0;
      tdi_sync_q   <= '0;
      trstn_sync_q <= '0;
      tck_prev_q   <= 1'b0;
    end else begin
      tck_sync_q   <= {tck_sync_q[0], tck_i};
      tms_sync_q   <= {tms_sync_q[0], tms_i};
      tdi_sync_q   <= {tdi_sync_q[0], tdi_i};
      trstn_sync_q <= {trstn_sync_q[0], trstn_i};
      tck_prev_q   <= tck_sync_q[1];
    end
  end

  assign tck_s      = tck_sync_q[1];
  assign tms_s      = tms_sync_q[1];
  assign tdi_s      = tdi_sync_q[1];
  assign trst       = ~trstn_sync_q[1];
  assign tck_rise   = tck_s & ~tck_prev_q;
  assign tck_fall   = ~tck_s & tck_prev_q;
  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_user   = (ir_q == USER_IR) && !sel_idcode;

  always_comb begin
    tap_next = state_q;
    case (state_q)
      TLR:     tap_next = tms_s ? TLR    : RTI;
      RTI:     tap_next = tms_s ? SELDR  : RTI;
      SELDR:   tap_next = tms_s ? SELIR  : CAPDR;
      CAPDR:   tap_next = tms_s ? EX1DR  : SHDR;
      SHDR:    tap_next = tms_s ? EX1DR  : SHDR;
      EX1DR:   tap_next = tms_s ? UPDDR  : PAUSDR;
      PAUSDR:  tap_next = tms_s ? EX2DR  : PAUSDR;
      EX2DR:   tap_next = tms_s ? UPDDR  : SHDR;
      UPDDR:   tap_next = tms_s ? SELDR  : RTI;
      SELIR:   tap_next = tms_s ? TLR    : CAPIR;
      CAPIR:   tap_next = tms_s ? EX1IR  : SHIR;
      SHIR:    tap_next = tms_s ? EX1IR  : SHIR;
      EX1IR:   tap_next = tms_s ? UPDIR  : PAUSIR;
      PAUSIR:  tap_next = tms_s ? EX2IR  : PAUSIR;
      EX2IR:   tap_next = tms_s ? UPDIR  : SHIR;
      UPDIR:   tap_next = tms_s ? SELDR  : RTI;
      default: tap_next = TLR;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    ir_shift_d     = ir_shift_q;
    dr_shift_d     = dr_shift_q;
    bypass_d       = bypass_q;
    tdo_d          = tdo_q;
    tdo_en_d       = tdo_en_q;
    user_data_d    = user_data_q;
    user_capture_d = 1'b0;
    user_update_d  = 1'b0;
    if (trst) begin
      // Takes priority over a coincident TCK edge; user data is preserved.
      state_d  = TLR;
      ir_d     = IR_IDCODE;
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
    end else begin
      if (tck_rise) begin
        state_d = tap_next;
        // Actions belong to the state being left.
        case (state_q)
          CAPIR: ir_shift_d = IR_CAPTURE;
          SHIR:  ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
          CAPDR: begin
            if (sel_idcode) begin
              dr_shift_d = IDCODE_VALUE;
            end else if (sel_user) begin
              dr_shift_d     = user_capture_i;
              user_capture_d = 1'b1;
            end else begin
              bypass_d = 1'b0;
            end
          end
          SHDR: begin
            if (sel_idcode || sel_user) begin
              dr_shift_d = {tdi_s, dr_shift_q[31:1]};
            end else begin
              bypass_d = tdi_s;
            end
          end
          default: ;
        endcase
        if (tap_next == UPDIR) begin
          ir_d = ir_shift_q;
        end
        if (tap_next == UPDDR && sel_user) begin
          user_data_d   = dr_shift_q;
          user_update_d = 1'b1;
        end
        if (tap_next == TLR) begin
          ir_d = IR_IDCODE;
        end
      end
      if (tck_fall) begin
        tdo_en_d = (state_q == SHIR) || (state_q == SHDR);
        if (state_q == SHIR) begin
          tdo_d = ir_shift_q[0];
        end else if (state_q == SHDR) begin
          tdo_d = (sel_idcode || sel_user) ? dr_shift_q[0] : bypass_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= TLR;
      ir_q           <= IR_IDCODE;
      ir_shift_q     <= '0;
      dr_shift_q     <= '0;
      bypass_q       <= 1'b0;
      tdo_q          <= 1'b0;
      tdo_en_q       <= 1'b0;
      user_data_q    <= '0;
      user_capture_q <= 1'b0;
      user_update_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ir_q           <= ir_d;
      ir_shift_q     <= ir_shift_d;
      dr_shift_q     <= dr_shift_d;
      bypass_q       <= bypass_d;
      tdo_q          <= tdo_d;
      tdo_en_q       <= tdo_en_d;
      user_data_q    <= user_data_d;
      user_capture_q <= user_capture_d;
      user_update_q  <= user_update_d;
    end
  end

  assign tdo_o          = tdo_q;
  assign tdo_en_o       = tdo_en_q;
  assign tap_reset_o    = (state_q == TLR);
  assign user_capture_o = user_capture_q;
  assign user_update_o  = user_update_q;
  assign user_data_o    = user_data_q;

endmodule
`default_nettype wire
